// File: rtl/frame_draw_pkg.sv
// Shared definitions for the frame drawers: draw-pass state encoding,
// source-select bus width and pixel coordinate width.
package frame_draw_pkg;

    localparam int SOURCE_SEL_ADDRW = 4;
    localparam int COORD_W          = 16;

    typedef enum logic [1:0] {
        AWAIT_WRITE    = 2'd0,
        ACTIVATE_WRITE = 2'd1,
        WRITE_ACTIVE   = 2'd2,
        WRITE_DONE     = 2'd3
    } draw_state_e;

endpackage

// File: rtl/raster_scan_ctr.sv
// Column/row scan counters: load a start point and exclusive end bounds,
// then step one pixel per enable in raster order.
module raster_scan_ctr
    import frame_draw_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [COORD_W-1:0] x_start_i,
    input  logic [COORD_W-1:0] y_start_i,
    input  logic [COORD_W:0]   x_end_i,
    input  logic [COORD_W:0]   y_end_i,
    output logic [COORD_W-1:0] col_o,
    output logic [COORD_W-1:0] row_o,
    output logic               last_o
);

    localparam logic [COORD_W:0] ONE = 1;

    logic [COORD_W-1:0] col_q, col_d, row_q, row_d, x_start_q;
    logic [COORD_W:0]   x_end_q, y_end_q;
    logic               col_wrap, row_wrap;

    assign col_wrap = (({1'b0, col_q} + ONE) == x_end_q);
    assign row_wrap = (({1'b0, row_q} + ONE) == y_end_q);
    assign last_o   = col_wrap && row_wrap;
    assign col_o    = col_q;
    assign row_o    = row_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = x_start_i;
            row_d = y_start_i;
        end else if (step_i) begin
            if (col_wrap) begin
                col_d = x_start_q;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q     <= '0;
            row_q     <= '0;
            x_start_q <= '0;
            x_end_q   <= '0;
            y_end_q   <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (load_i) begin
                x_start_q <= x_start_i;
                x_end_q   <= x_end_i;
                y_end_q   <= y_end_i;
            end
        end
    end

endmodule

// File: rtl/rect_fill_draw.sv
// Rectangle fill drawer on the shared frame-write bus, clipped to the frame.
// Define RECT_FILL_CHECKER_EN to add the alternate-color checker fill.
module rect_fill_draw #(
    parameter int SOURCE_ID        = 0,
    parameter int COLOR_DEPTH      = 9,
    parameter int DRAW_WIDTH       = 640,
    parameter int DRAW_HEIGHT      = 480,
    parameter int SOURCE_SEL_ADDRW = frame_draw_pkg::SOURCE_SEL_ADDRW
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic [SOURCE_SEL_ADDRW-1:0]       write_source_sel,
    input  logic                              write_awaited,
    input  logic [frame_draw_pkg::COORD_W-1:0] rect_x,
    input  logic [frame_draw_pkg::COORD_W-1:0] rect_y,
    input  logic [frame_draw_pkg::COORD_W-1:0] rect_w,
    input  logic [frame_draw_pkg::COORD_W-1:0] rect_h,
    input  logic [COLOR_DEPTH-1:0]            fill_color,
    input  logic [COLOR_DEPTH-1:0]            alt_color,
    input  logic                              checker_mode,
    output logic                              busy,
    output logic                              done,
    output logic                              write_active,
    output logic [COLOR_DEPTH-1:0]            write_color_data,
    output logic                              write_transparent,
    output logic [31:0]                       write_x_addr,
    output logic [31:0]                       write_y_addr,
    output frame_draw_pkg::draw_state_e       dbg_state
);
    import frame_draw_pkg::*;

    localparam logic [COORD_W:0] X_LIM = DRAW_WIDTH[COORD_W:0];
    localparam logic [COORD_W:0] Y_LIM = DRAW_HEIGHT[COORD_W:0];

    draw_state_e            state_q;
    logic                   busy_q, done_q, active_q;
    logic [COLOR_DEPTH-1:0] fill_q, color;
    logic [COORD_W:0]       x_sum, y_sum, x_end, y_end;
    logic [COORD_W-1:0]     col, row;
    logic                   sel_hit, empty, last;

    assign sel_hit = (write_source_sel == SOURCE_SEL_ADDRW'(SOURCE_ID));

    // 17-bit sums so a rectangle near 0xFFFF cannot wrap back into the frame
    assign x_sum = {1'b0, rect_x} + {1'b0, rect_w};
    assign y_sum = {1'b0, rect_y} + {1'b0, rect_h};
    assign x_end = (x_sum > X_LIM) ? X_LIM : x_sum;
    assign y_end = (y_sum > Y_LIM) ? Y_LIM : y_sum;
    assign empty = (rect_w == '0) || (rect_h == '0) ||
                   ({1'b0, rect_x} >= X_LIM) || ({1'b0, rect_y} >= Y_LIM);

    raster_scan_ctr u_scan (
        .clk_i     (clk),
        .rst_ni    (resetN),
        .load_i    (state_q == ACTIVATE_WRITE && !empty),
        .step_i    (state_q == WRITE_ACTIVE),
        .x_start_i (rect_x),
        .y_start_i (rect_y),
        .x_end_i   (x_end),
        .y_end_i   (y_end),
        .col_o     (col),
        .row_o     (row),
        .last_o    (last)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= AWAIT_WRITE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            active_q <= 1'b0;
            fill_q   <= '0;
        end else begin
            case (state_q)
                AWAIT_WRITE: begin
                    done_q <= 1'b0;
                    if (write_awaited && sel_hit) begin
                        state_q <= ACTIVATE_WRITE;
                        busy_q  <= 1'b1;
                    end
                end
                ACTIVATE_WRITE: begin
                    fill_q <= fill_color;
                    if (empty) begin
                        state_q <= WRITE_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q  <= WRITE_ACTIVE;
                        active_q <= 1'b1;
                    end
                end
                WRITE_ACTIVE: begin
                    if (last) begin
                        state_q  <= WRITE_DONE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= AWAIT_WRITE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RECT_FILL_CHECKER_EN
    logic                   checker_q, x0_lsb_q, y0_lsb_q;
    logic [COLOR_DEPTH-1:0] alt_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            checker_q <= 1'b0;
            x0_lsb_q  <= 1'b0;
            y0_lsb_q  <= 1'b0;
            alt_q     <= '0;
        end else if (state_q == ACTIVATE_WRITE) begin
            checker_q <= checker_mode;
            x0_lsb_q  <= rect_x[0];
            y0_lsb_q  <= rect_y[0];
            alt_q     <= alt_color;
        end
    end

    // bit 0 of (col-x0)^(row-y0) only depends on the operand LSBs
    assign color = (checker_q && (col[0] ^ x0_lsb_q ^ row[0] ^ y0_lsb_q)) ? alt_q : fill_q;
`else
    logic unused_checker;
    assign unused_checker = ^{checker_mode, alt_color};
    assign color = fill_q;
`endif

    assign busy              = busy_q;
    assign done              = done_q;
    assign dbg_state         = state_q;
    assign write_active      = sel_hit ? active_q : 1'bz;
    assign write_color_data  = sel_hit ? color : {COLOR_DEPTH{1'bz}};
    assign write_transparent = sel_hit ? 1'b0 : 1'bz;
    assign write_x_addr      = sel_hit ? {{(32-COORD_W){1'b0}}, col} : {32{1'bz}};
    assign write_y_addr      = sel_hit ? {{(32-COORD_W){1'b0}}, row} : {32{1'bz}};

endmodule

// File: tb/tb_rect_fill_draw.sv
// Scoreboard bench for rect_fill_draw: driver pushes expected pixels,
// a negedge monitor pops and compares every bus write.
module tb_rect_fill_draw;
    import frame_draw_pkg::*;

    localparam int DW = 640;
    localparam int DH = 480;
    localparam int CD = 9;
    localparam int PW = 2 * COORD_W + CD;

    logic           clk;
    logic           resetN;
    logic [3:0]     write_source_sel;
    logic           write_awaited;
    logic [15:0]    rect_x, rect_y, rect_w, rect_h;
    logic [CD-1:0]  fill_color, alt_color;
    logic           checker_mode;
    wire            busy, done, write_active, write_transparent;
    wire  [CD-1:0]  write_color_data;
    wire  [31:0]    write_x_addr, write_y_addr;
    draw_state_e    dbg_state;

    logic [PW-1:0]  exp_q[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    int             n_writes = 0;
    int             n_done   = 0;
    bit             sb_ignore = 0;

    rect_fill_draw dut (
        .clk               (clk),
        .resetN            (resetN),
        .write_source_sel  (write_source_sel),
        .write_awaited     (write_awaited),
        .rect_x            (rect_x),
        .rect_y            (rect_y),
        .rect_w            (rect_w),
        .rect_h            (rect_h),
        .fill_color        (fill_color),
        .alt_color         (alt_color),
        .checker_mode      (checker_mode),
        .busy              (busy),
        .done              (done),
        .write_active      (write_active),
        .write_color_data  (write_color_data),
        .write_transparent (write_transparent),
        .write_x_addr      (write_x_addr),
        .write_y_addr      (write_y_addr),
        .dbg_state         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every bus write must match the head of the expected queue.
    always @(negedge clk) begin
        if (done === 1'b1) n_done++;
        if (resetN === 1'b1 && write_active === 1'b1 && !sb_ignore) begin
            n_writes++;
            check("addr_in_frame", 64'((write_x_addr < DW) && (write_y_addr < DH)), 64'd1);
            check("transparent", 64'(write_transparent), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {write_x_addr, write_y_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("pixel", 64'({write_x_addr[15:0], write_y_addr[15:0], write_color_data}),
                      64'(exp_q.pop_front()));
            end
        end
    end

    // Drive one pass; expected pixels come from a clipped raster model,
    // exp_writes is the hand-computed pixel count.
    task automatic run_rect(input int x, input int y, input int w, input int h,
                            input int fill, input int alt, input bit chk, input int exp_writes);
        int xe, ye, lat, col;
        bit seen;
        xe = (x + w > DW) ? DW : x + w;
        ye = (y + h > DH) ? DH : y + h;
        for (int r = y; r < ye; r++) begin
            for (int c = x; c < xe; c++) begin
                col = fill;
`ifdef RECT_FILL_CHECKER_EN
                if (chk && ((((c - x) ^ (r - y)) & 1) == 1)) col = alt;
`endif
                exp_q.push_back({16'(c), 16'(r), 9'(col)});
            end
        end
        n_writes = 0;
        @(posedge clk); #1;
        rect_x = 16'(x); rect_y = 16'(y); rect_w = 16'(w); rect_h = 16'(h);
        fill_color = 9'(fill); alt_color = 9'(alt); checker_mode = chk;
        write_awaited = 1'b1;
        @(posedge clk); #1;
        write_awaited = 1'b0;
        check("busy_activate", 64'(busy), 64'd1);
        lat  = 1;
        seen = 0;
        while (!seen && lat < 5000) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) begin
                rect_x = 16'd3; rect_y = 16'd3; rect_w = 16'd50; rect_h = 16'd50;
                fill_color = 9'h0F0; alt_color = 9'h00F; checker_mode = ~chk;
            end
            if (done === 1'b1) seen = 1;
        end
        check("done_latency", 64'(seen ? lat : -1), 64'(exp_writes + 2));
        check("write_count", 64'(n_writes), 64'(exp_writes));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        check("done_pulse", 64'(done), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        int done_before;
        resetN = 1'b0;
        write_source_sel = 4'd0; write_awaited = 1'b0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
        fill_color = '0; alt_color = '0; checker_mode = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_active", 64'(write_active), 64'd0);
        check("rst_x", 64'(write_x_addr), 64'd0);
        check("rst_y", 64'(write_y_addr), 64'd0);
        check("rst_color", 64'(write_color_data), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(AWAIT_WRITE));
        @(negedge clk); resetN = 1'b1;

        run_rect(10, 20, 4, 3, 'h1A5, 'h000, 1'b0, 12);
        run_rect(638, 478, 5, 5, 'h0C3, 'h000, 1'b0, 4);
        run_rect(5, 5, 0, 3, 'h111, 'h000, 1'b0, 0);
        run_rect(700, 10, 4, 4, 'h111, 'h000, 1'b0, 0);
        run_rect(0, 480, 4, 4, 'h111, 'h000, 1'b0, 0);
        run_rect(0, 0, 2, 2, 'h000, 'h1FF, 1'b1, 4);
        run_rect(7, 3, 3, 2, 'h055, 'h1AA, 1'b1, 6);

        // reset in the middle of a long pass
        sb_ignore = 1;
        @(posedge clk); #1;
        rect_x = 16'd0; rect_y = 16'd0; rect_w = 16'd50; rect_h = 16'd4;
        fill_color = 9'h1F0; checker_mode = 1'b0; write_awaited = 1'b1;
        @(posedge clk); #1;
        write_awaited = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midpass_active", 64'(write_active), 64'd1);
        done_before = n_done;
        resetN = 1'b0;
        #1;
        check("mrst_active", 64'(write_active), 64'd0);
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_x", 64'(write_x_addr), 64'd0);
        check("mrst_y", 64'(write_y_addr), 64'd0);
        check("mrst_color", 64'(write_color_data), 64'd0);
        check("mrst_state", 64'(dbg_state), 64'(AWAIT_WRITE));
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_no_done", 64'(n_done - done_before), 64'd0);
        check("mrst_idle", 64'(dbg_state), 64'(AWAIT_WRITE));
        sb_ignore = 0;

        // another source owns the bus
        write_source_sel = 4'd1;
        write_awaited = 1'b1;
        #1;
        check("z_active", 64'(write_active === 1'bz), 64'd1);
        check("z_transparent", 64'(write_transparent === 1'bz), 64'd1);
        check("z_color", 64'(write_color_data === {CD{1'bz}}), 64'd1);
        check("z_x", 64'(write_x_addr === {32{1'bz}}), 64'd1);
        check("z_y", 64'(write_y_addr === {32{1'bz}}), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("desel_state", 64'(dbg_state), 64'(AWAIT_WRITE));
        check("desel_busy", 64'(busy), 64'd0);
        write_awaited = 1'b0;
        write_source_sel = 4'd0;

        run_rect(100, 200, 3, 1, 'h0AB, 'h000, 1'b0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rect_fill_draw.md
RECT_FILL_DRAW -- requirements
Module: rect_fill_draw

Interface
REQ-001 SHALL have parameter SOURCE_ID, default 0, bus source ID this drawer answers to.
REQ-002 SHALL have parameter COLOR_DEPTH, default 9, pixel color width.
REQ-003 SHALL have parameters DRAW_WIDTH, default 640, and DRAW_HEIGHT, default 480, giving the frame size in pixels.
REQ-004 SHALL have parameter SOURCE_SEL_ADDRW, default 4, width of the source select bus.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-006 SHALL have port resetN, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port write_source_sel, input, SOURCE_SEL_ADDRW, frame-manager source select.
REQ-008 SHALL have port write_awaited, input, 1, frame manager requests a draw pass.
REQ-009 SHALL have ports rect_x and rect_y, input, 16 each, rectangle origin in pixels.
REQ-010 SHALL have ports rect_w and rect_h, input, 16 each, rectangle size in pixels.
REQ-011 SHALL have ports fill_color and alt_color, input, COLOR_DEPTH each, primary and checker colors.
REQ-012 SHALL have port checker_mode, input, 1, selecting checker fill.
REQ-013 SHALL have port busy, output, 1, high from ACTIVATE through WRITE_DONE.
REQ-014 SHALL have port done, output, 1, single-cycle pulse at pass end.
REQ-015 SHALL have outputs write_active (1), write_color_data (COLOR_DEPTH), write_transparent (1), write_x_addr (32) and write_y_addr (32), all shared-bus outputs; each is high-Z whenever write_source_sel != SOURCE_ID.

Function
REQ-016 SHALL implement the states AWAIT_WRITE, ACTIVATE_WRITE, WRITE_ACTIVE and WRITE_DONE.
REQ-017 SHALL go from AWAIT_WRITE to ACTIVATE_WRITE when write_awaited=1 and write_source_sel==SOURCE_ID.
REQ-018 SHALL, in ACTIVATE_WRITE, latch all rect and color inputs and clip to the frame: x_end=min(rect_x+rect_w, DRAW_WIDTH), y_end=min(rect_y+rect_h, DRAW_HEIGHT), computed 17-bit, no wrap.
REQ-019 SHALL go from ACTIVATE_WRITE to WRITE_DONE with zero writes if the clipped region is empty (w=0, h=0, rect_x>=DRAW_WIDTH or rect_y>=DRAW_HEIGHT); otherwise it SHALL go to WRITE_ACTIVE at (column=rect_x, row=rect_y).
REQ-020 SHALL, in WRITE_ACTIVE, emit one pixel per cycle in raster order with write_active=1; column increments and at x_end-1 wraps to rect_x with row+1.
REQ-021 SHALL go from WRITE_ACTIVE to WRITE_DONE after the pixel (x_end-1, y_end-1); the pass is exactly clipped_w*clipped_h cycles.
REQ-022 SHALL go from WRITE_DONE to AWAIT_WRITE, with done=1 for that one cycle.
REQ-023 SHALL drive write_color_data combinationally from the current column and row, with zero latency between address and color.
REQ-024 SHALL drive write_transparent=0 whenever selected.
REQ-025 SHALL ignore input changes during a pass, since only latched values are used.
REQ-026 SHALL let the pass continue if write_source_sel deasserts mid-pass; the outputs go high-Z and the writes are lost.

Reset
REQ-027 SHALL, on resetN=0 (any state, including mid-pass), immediately enter AWAIT_WRITE and clear the counters and latches to 0.
REQ-028 SHALL hold busy=0 and done=0 during reset; when selected during reset, write_active=0, the addresses are 0 and the color is 0.

Configuration
REQ-029 SHALL include checker fill when RECT_FILL_CHECKER_EN is defined: color = alt_color when checker_mode=1 and ((column-rect_x)^(row-rect_y)) bit 0 is 1; otherwise color = fill_color.
REQ-030 SHALL, without RECT_FILL_CHECKER_EN, ignore checker_mode and alt_color and always use fill_color, with no checker logic synthesised.

Structure
REQ-031 SHALL place the draw-state enum, SOURCE_SEL_ADDRW and the coordinate width constant in package frame_draw_pkg, shared with other drawers.
REQ-032 SHALL use one sub-module, raster_scan_ctr, holding the column and row counters with start, end and wrap logic.

Verification
REQ-033 SHALL cover: sel=SOURCE_ID, awaited=1, rect (10,20,4,3), fill=0x1A5 -> 12 writes, (10..13, 20..22) in raster order, color 0x1A5, then done pulse.
REQ-034 SHALL cover: rect (638,478,5,5) -> 4 writes, (638..639, 478..479), no address >= frame size.
REQ-035 SHALL cover: rect_w=0 or rect_x=700 -> 0 writes, done 2 cycles after trigger.
REQ-036 SHALL cover: with RECT_FILL_CHECKER_EN, checker_mode=1, fill=0x000, alt=0x1FF, rect (0,0,2,2) -> colors 0x000, 0x1FF, 0x1FF, 0x000.
REQ-037 SHALL cover: resetN pulsed low mid-pass -> all outputs at reset values same cycle, state AWAIT_WRITE, no done.
REQ-038 SHALL cover: sel != SOURCE_ID -> all bus outputs Z; awaited ignored.
